// File: rtl/core_exec_pkg.sv
// Shared types for the multi-cycle execution unit: opcodes, FSM states and
// opcode classification helpers.
package core_exec_pkg;

  typedef enum logic [4:0] {
    ALU_ADD   = 5'd0,
    ALU_SUB   = 5'd1,
    ALU_SLL   = 5'd2,
    ALU_SRL   = 5'd3,
    ALU_SRA   = 5'd4,
    ALU_XOR   = 5'd5,
    ALU_OR    = 5'd6,
    ALU_AND   = 5'd7,
    ALU_EQ    = 5'd8,
    ALU_LT    = 5'd9,
    ALU_LTU   = 5'd10,
    ALU_MUL   = 5'd11,
    ALU_MULHU = 5'd12,
    ALU_DIVU  = 5'd13,
    ALU_REMU  = 5'd14,
    ALU_DIV   = 5'd15,
    ALU_REM   = 5'd16
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_DONE
  } state_e;

  function automatic logic is_multicycle(alu_op_e op);
    return op inside {ALU_MUL, ALU_MULHU, ALU_DIVU, ALU_REMU, ALU_DIV, ALU_REM};
  endfunction

  function automatic logic is_mul_op(alu_op_e op);
    return op inside {ALU_MUL, ALU_MULHU};
  endfunction

endpackage

// File: rtl/core_muldiv.sv
// Iterative datapaths: shift-add multiplier and restoring divider, one bit
// per step. Sequencing (step count, completion) is owned by the parent FSM.
module core_muldiv
  import core_exec_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  step,
  input  logic                  last,
  input  alu_op_e               op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int W = DATA_WIDTH;

  logic [2*W-1:0] prod;
  logic [W-1:0]   opnd;
  logic [W-1:0]   quo;
  logic [W-1:0]   rem;
  alu_op_e        op_q;
  logic           neg_q;
  logic           neg_r;

  logic           is_signed;
  logic           a_neg;
  logic           b_neg;
  logic [W-1:0]   a_mag;
  logic [W-1:0]   b_mag;
  logic [W:0]     mul_sum;
  logic [W:0]     trial;

  always_comb begin
    is_signed = (op == ALU_DIV) || (op == ALU_REM);
    a_neg     = is_signed & a[W-1];
    b_neg     = is_signed & b[W-1];
    a_mag     = a_neg ? -a : a;
    b_mag     = b_neg ? -b : b;
    mul_sum   = {1'b0, prod[2*W-1:W]} + (prod[0] ? {1'b0, opnd} : '0);
    trial     = {rem, quo[W-1]} - {1'b0, opnd};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prod  <= '0;
      opnd  <= '0;
      quo   <= '0;
      rem   <= '0;
      op_q  <= ALU_MUL;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      done  <= 1'b0;
    end else if (start) begin
      op_q <= op;
      done <= 1'b0;
      if (is_mul_op(op)) begin
        prod <= {{W{1'b0}}, b};
        opnd <= a;
      end else begin
        quo   <= a_mag;
        rem   <= '0;
        opnd  <= b_mag;
        // A zero divisor keeps the all-ones quotient unsigned regardless of sign
        neg_q <= (a_neg ^ b_neg) && (b != '0);
        neg_r <= a_neg;
      end
    end else if (step) begin
      if (is_mul_op(op_q)) begin
        prod <= {mul_sum, prod[W-1:1]};
      end else if (!trial[W]) begin
        rem <= trial[W-1:0];
        quo <= {quo[W-2:0], 1'b1};
      end else begin
        rem <= {rem[W-2:0], quo[W-1]};
        quo <= {quo[W-2:0], 1'b0};
      end
      if (last) done <= 1'b1;
    end
  end

  always_comb begin
    result = '0;
    case (op_q)
      ALU_MUL:            result = prod[W-1:0];
      ALU_MULHU:          result = prod[2*W-1:W];
      ALU_DIVU, ALU_DIV:  result = neg_q ? -quo : quo;
      ALU_REMU, ALU_REM:  result = neg_r ? -rem : rem;
      default:            result = '0;
    endcase
  end

endmodule

// File: rtl/core_exec_multicycle.sv
// Execution unit: single-cycle ALU ops with a registered result, plus
// iterative mul/div sequenced by an FSM, behind valid/ready handshakes.
module core_exec_multicycle
  import core_exec_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5,
  parameter int OP_WIDTH    = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [DATA_WIDTH-1:0] operands_a_i,
  input  logic [DATA_WIDTH-1:0] operands_b_i,
  input  logic [OP_WIDTH-1:0]   alu_op_i,
  input  logic                  invert_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic [DATA_WIDTH:0]   adder_o,
  output logic                  comp_o,
  output logic                  busy_o
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  state_e                  state;
  logic [CNT_W-1:0]        cnt;
  alu_op_e                 op;
  logic                    accept;
  logic                    md_start;
  logic                    md_done;
  logic [DATA_WIDTH-1:0]   md_result;

  logic [DATA_WIDTH:0]     sum;
  logic [DATA_WIDTH:0]     diff;
  logic [SHAMT_WIDTH-1:0]  shamt;
  logic [DATA_WIDTH-1:0]   alu_res;
  logic [DATA_WIDTH:0]     alu_add;
  logic                    alu_comp;
  logic                    raw_cmp;
  logic                    is_cmp;

  assign op       = alu_op_e'(alu_op_i);
  assign busy_o   = (state == ST_MUL) || (state == ST_DIV);
  assign ready_o  = (state == ST_IDLE) && (!valid_o || ready_i);
  assign accept   = valid_i && ready_o;
  assign md_start = accept && is_multicycle(op);
  assign shamt    = operands_b_i[SHAMT_WIDTH-1:0];

  always_comb begin
    sum     = {1'b0, operands_a_i} + {1'b0, operands_b_i};
    diff    = {1'b0, operands_a_i} - {1'b0, operands_b_i};
    alu_res = '0;
    alu_add = sum;
    raw_cmp = 1'b0;
    is_cmp  = 1'b0;
    case (op)
      ALU_ADD: alu_res = sum[DATA_WIDTH-1:0];
      ALU_SUB: begin
        alu_res = diff[DATA_WIDTH-1:0];
        alu_add = diff;
      end
      ALU_SLL: alu_res = operands_a_i << shamt;
      ALU_SRL: alu_res = operands_a_i >> shamt;
      ALU_SRA: alu_res = DATA_WIDTH'($signed(operands_a_i) >>> shamt);
      ALU_XOR: alu_res = operands_a_i ^ operands_b_i;
      ALU_OR:  alu_res = operands_a_i | operands_b_i;
      ALU_AND: alu_res = operands_a_i & operands_b_i;
      ALU_EQ: begin
        is_cmp  = 1'b1;
        raw_cmp = (operands_a_i == operands_b_i);
        alu_add = diff;
      end
      ALU_LT: begin
        is_cmp  = 1'b1;
        raw_cmp = $signed(operands_a_i) < $signed(operands_b_i);
        alu_add = diff;
      end
      ALU_LTU: begin
        is_cmp  = 1'b1;
        raw_cmp = diff[DATA_WIDTH];
        alu_add = diff;
      end
      default: alu_res = '0;
    endcase
    alu_comp = is_cmp & (raw_cmp ^ invert_i);
    if (is_cmp) alu_res = {{(DATA_WIDTH-1){1'b0}}, alu_comp};
  end

  core_muldiv #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_muldiv (
    .clk    (clk_i),
    .rst    (rst_i),
    .start  (md_start),
    .step   (busy_o),
    .last   (cnt == CNT_LAST),
    .op     (op),
    .a      (operands_a_i),
    .b      (operands_b_i),
    .done   (md_done),
    .result (md_result)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      valid_o  <= 1'b0;
      result_o <= '0;
      adder_o  <= '0;
      comp_o   <= 1'b0;
    end else begin
      if (valid_o && ready_i) valid_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (is_multicycle(op)) begin
              state <= is_mul_op(op) ? ST_MUL : ST_DIV;
              cnt   <= '0;
            end else begin
              result_o <= alu_res;
              adder_o  <= alu_add;
              comp_o   <= alu_comp;
              valid_o  <= 1'b1;
            end
          end
        end
        ST_MUL, ST_DIV: begin
          if (cnt == CNT_LAST) begin
            state <= ST_DONE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          // Hold here until any earlier result has been taken
          if (md_done && (!valid_o || ready_i)) begin
            result_o <= md_result;
            adder_o  <= '0;
            comp_o   <= 1'b0;
            valid_o  <= 1'b1;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_exec_multicycle.sv
// Self-checking bench: directed literal cases plus randomized traffic checked
// every cycle against an arithmetic reference model of the execution unit.
module tb_core_exec_multicycle;
  import core_exec_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_i, valid_i, ready_o, invert_i, valid_o, ready_i, comp_o, busy_o;
  logic [W-1:0] a_i, b_i, result_o;
  logic [4:0]   op_i;
  logic [W:0]   adder_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  core_exec_multicycle #(
    .DATA_WIDTH (W),
    .SHAMT_WIDTH(5),
    .OP_WIDTH   (5)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .operands_a_i(a_i),
    .operands_b_i(b_i),
    .alu_op_i    (op_i),
    .invert_i    (invert_i),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .result_o    (result_o),
    .adder_o     (adder_o),
    .comp_o      (comp_o),
    .busy_o      (busy_o)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s actual=timeout required=handshake", name);
  endtask

  // Reference: results straight from the arithmetic definition of each op.
  function automatic void ref_op(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic inv, output logic [W-1:0] res, output logic [W:0] add,
                                 output logic cmp, output bit multi);
    longint      sa, sb;
    logic [63:0] p;
    logic        raw;
    sa    = longint'($signed(a));
    sb    = longint'($signed(b));
    p     = 64'(a) * 64'(b);
    add   = 33'(a) + 33'(b);
    res   = '0;
    cmp   = 1'b0;
    raw   = 1'b0;
    multi = 1'b0;
    case (op)
      ALU_ADD:   res = a + b;
      ALU_SUB:   begin res = a - b; add = 33'(a) - 33'(b); end
      ALU_SLL:   res = a << b[4:0];
      ALU_SRL:   res = a >> b[4:0];
      ALU_SRA:   res = W'(sa >>> b[4:0]);
      ALU_XOR:   res = a ^ b;
      ALU_OR:    res = a | b;
      ALU_AND:   res = a & b;
      ALU_EQ, ALU_LT, ALU_LTU: begin
        if (op == ALU_EQ)      raw = (a == b);
        else if (op == ALU_LT) raw = (sa < sb);
        else                   raw = (a < b);
        cmp = raw ^ inv;
        res = W'(cmp);
        add = 33'(a) - 33'(b);
      end
      ALU_MUL:   begin multi = 1; add = '0; res = p[31:0]; end
      ALU_MULHU: begin multi = 1; add = '0; res = p[63:32]; end
      ALU_DIVU:  begin multi = 1; add = '0; res = (b == 0) ? '1 : a / b; end
      ALU_REMU:  begin multi = 1; add = '0; res = (b == 0) ? a : a % b; end
      ALU_DIV: begin
        multi = 1; add = '0;
        if (b == 0) res = '1;
        else if (a == 32'h8000_0000 && b == '1) res = a;
        else res = W'(sa / sb);
      end
      ALU_REM: begin
        multi = 1; add = '0;
        if (b == 0) res = a;
        else if (a == 32'h8000_0000 && b == '1) res = '0;
        else res = W'(sa % sb);
      end
      default: res = '0;
    endcase
  endfunction

  typedef struct {
    logic [W-1:0] res;
    logic [W:0]   add;
    logic         cmp;
    bit           multi;
    int           ready_at;
  } exp_t;

  exp_t q[$];
  bit   chk_rst = 0;

  // Request seen at cycle c: single-cycle result visible at c+1, multi-cycle
  // at c+W+2 (valid rises on the (W+1)th edge after the accepting edge).
  always @(negedge clk) begin : monitor
    bit           ev, idle, eb, er;
    exp_t         e;
    logic [W-1:0] r;
    logic [W:0]   ad;
    logic         cp;
    bit           mu;
    ev   = (q.size() > 0) && (cyc >= q[0].ready_at);
    idle = !((q.size() > 0) && (cyc < q[0].ready_at));
    eb   = (q.size() > 0) && q[0].multi && (cyc < q[0].ready_at - 1);
    er   = idle && (!ev || ready_i);
    chk("mon_valid", 64'(valid_o), 64'(ev));
    chk("mon_busy",  64'(busy_o),  64'(eb));
    chk("mon_ready", 64'(ready_o), 64'(er));
    if (ev) begin
      chk("mon_result", 64'(result_o), 64'(q[0].res));
      chk("mon_adder",  64'(adder_o),  64'(q[0].add));
      chk("mon_comp",   64'(comp_o),   64'(q[0].cmp));
    end
    if (chk_rst) begin
      chk("rst_result", 64'(result_o), 64'd0);
      chk("rst_adder",  64'(adder_o),  64'd0);
      chk("rst_comp",   64'(comp_o),   64'd0);
    end
    chk_rst = rst_i;
    if (rst_i) begin
      q.delete();
    end else begin
      if (ev && ready_i) void'(q.pop_front());
      if (valid_i && er) begin
        ref_op(op_i, a_i, b_i, invert_i, r, ad, cp, mu);
        e.res = r; e.add = ad; e.cmp = cp; e.multi = mu;
        e.ready_at = cyc + (mu ? W + 2 : 1);
        q.push_back(e);
      end
    end
  end

  task automatic issue(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic inv, output int acc);
    @(posedge clk); #1;
    valid_i = 1; op_i = op; a_i = a; b_i = b; invert_i = inv;
    acc = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ready_o) begin acc = cyc; break; end
    end
    if (acc < 0) fail_timeout("issue");
    @(posedge clk); #1;
    valid_i = 0;
  endtask

  task automatic await(input string name, input int acc, input logic [W-1:0] exp_res,
                       input int exp_lat, output int busy_cnt);
    int seen;
    seen = -1;
    busy_cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (busy_o) busy_cnt++;
      if (valid_o) begin seen = cyc; break; end
    end
    if (seen < 0) begin
      fail_timeout(name);
    end else begin
      chk(name, 64'(result_o), 64'(exp_res));
      chk({name, "_lat"}, 64'(seen - acc), 64'(exp_lat));
    end
  endtask

  task automatic run(input string name, input logic [4:0] op, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic inv, input logic [W-1:0] exp_res);
    int acc, bc;
    issue(op, a, b, inv, acc);
    await(name, acc, exp_res, is_multicycle(alu_op_e'(op)) ? W + 2 : 1, bc);
  endtask

  function automatic logic [W-1:0] rnd_val();
    case ($urandom_range(0, 6))
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return W'($urandom_range(0, 9));
      4: return -W'($urandom_range(1, 9));
      default: return W'($urandom);
    endcase
  endfunction

  initial begin : stim
    int acc, bc;
    bit any_v;
    rst_i = 1; valid_i = 0; ready_i = 1; invert_i = 0; op_i = '0; a_i = '0; b_i = '0;
    repeat (3) @(posedge clk);
    #1 rst_i = 0;

    issue(ALU_ADD, 32'hFFFF_FFFF, 32'd1, 0, acc);
    await("add_wrap", acc, 32'd0, 1, bc);
    chk("add_wrap_adder", 64'(adder_o), 64'h1_0000_0000);
    issue(ALU_MUL, 32'd7, 32'd6, 0, acc);
    await("mul_7x6", acc, 32'd42, W + 2, bc);
    chk("mul_busy_cycles", 64'(bc), 64'd32);
    run("div_m7_2",   ALU_DIV,   -32'sd7, 32'd2, 0, 32'hFFFF_FFFD);
    run("rem_m7_2",   ALU_REM,   -32'sd7, 32'd2, 0, 32'hFFFF_FFFF);
    run("divu_by0",   ALU_DIVU,  32'd5, 32'd0, 0, 32'hFFFF_FFFF);
    run("remu_by0",   ALU_REMU,  32'd5, 32'd0, 0, 32'd5);
    run("div_ovf",    ALU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h8000_0000);
    run("rem_ovf",    ALU_REM,   32'h8000_0000, 32'hFFFF_FFFF, 0, 32'd0);
    run("div_s_by0",  ALU_DIV,   -32'sd7, 32'd0, 0, 32'hFFFF_FFFF);
    run("rem_s_by0",  ALU_REM,   -32'sd7, 32'd0, 0, 32'hFFFF_FFF9);
    run("mulhu_max",  ALU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFE);
    run("sra_min",    ALU_SRA,   32'h8000_0000, 32'd31, 0, 32'hFFFF_FFFF);
    run("lt_inv",     ALU_LT,    32'hFFFF_FFFF, 32'd1, 1, 32'd0);
    run("unknown_op", 5'd25,     32'd3, 32'd4, 0, 32'd0);

    // Back-to-back single-cycle requests, then a stalled consumer.
    @(posedge clk); #1;
    ready_i = 1; valid_i = 1; op_i = ALU_ADD; a_i = 1; b_i = 2; invert_i = 0;
    @(negedge clk); chk("b2b_ready0", 64'(ready_o), 64'd1);
    @(posedge clk); #1; a_i = 3; b_i = 4;
    @(negedge clk); chk("b2b_res0", 64'(result_o), 64'd3); chk("b2b_valid0", 64'(valid_o), 64'd1);
    @(posedge clk); #1; op_i = ALU_LT; a_i = 5; b_i = 9;
    @(negedge clk); chk("b2b_res1", 64'(result_o), 64'd7); chk("b2b_valid1", 64'(valid_o), 64'd1);
    @(posedge clk); #1; ready_i = 0; op_i = ALU_ADD; a_i = 10; b_i = 10;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_res", 64'(result_o), 64'd1);
      chk("stall_comp", 64'(comp_o), 64'd1);
      chk("stall_ready", 64'(ready_o), 64'd0);
    end
    @(posedge clk); #1; ready_i = 1;
    @(posedge clk); #1; valid_i = 0;
    chk("b2b_after_stall", 64'(result_o), 64'd20);

    // Reset in the middle of a divide.
    issue(ALU_DIVU, 32'd1000, 32'd7, 0, acc);
    repeat (9) @(posedge clk);
    #1 rst_i = 1;
    @(posedge clk); #1 rst_i = 0;
    @(negedge clk);
    chk("rst_ready", 64'(ready_o), 64'd1);
    chk("rst_busy", 64'(busy_o), 64'd0);
    any_v = 0;
    for (int i = 0; i < W + 6; i++) begin
      @(negedge clk);
      if (valid_o) any_v = 1;
    end
    chk("rst_no_valid", 64'(any_v), 64'd0);
    run("post_rst_add", ALU_ADD, 32'd2, 32'd3, 0, 32'd5);

    // Randomized traffic, checked by the monitor.
    for (int n = 0; n < 3000; n++) begin
      int r;
      @(posedge clk); #1;
      rst_i    = ($urandom_range(0, 399) == 0);
      ready_i  = ($urandom_range(0, 3) != 0);
      valid_i  = ($urandom_range(0, 9) < 7);
      invert_i = $urandom_range(0, 1);
      r = $urandom_range(0, 99);
      if (r < 55)      op_i = 5'($urandom_range(0, 10));
      else if (r < 88) op_i = 5'($urandom_range(11, 16));
      else             op_i = 5'($urandom_range(17, 31));
      a_i = rnd_val();
      b_i = rnd_val();
    end
    @(posedge clk); #1;
    rst_i = 0; valid_i = 0; ready_i = 1;
    repeat (W + 6) @(posedge clk);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    bad++;
    $display("FAIL watchdog actual=running required=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/core_exec_multicycle.md
CORE_EXEC_MULTICYCLE -- requirements
Module: core_exec_multicycle

Interface
REQ-001 Parameter DATA_WIDTH, default 32, operand/result width; legal values are 8, 16, 32 and 64.
REQ-002 Parameter SHAMT_WIDTH, default 5, shift-amount width; SHALL equal $clog2(DATA_WIDTH).
REQ-003 Parameter OP_WIDTH, default 5, width of alu_op_i.
REQ-004 clk_i  in  1  single clock; all state updates on rising edge.
REQ-005 rst_i  in  1  reset, synchronous, active-high.
REQ-006 valid_i  in  1  request valid.
REQ-007 ready_o  out  1  unit can accept a request this cycle.
REQ-008 operands_a_i  in  DATA_WIDTH  operand A.
REQ-009 operands_b_i  in  DATA_WIDTH  operand B.
REQ-010 alu_op_i  in  OP_WIDTH  operation code (alu_op_e).
REQ-011 invert_i  in  1  inverts comp_o for the compare ops EQ, LT and LTU.
REQ-012 valid_o  out  1  result valid.
REQ-013 ready_i  in  1  consumer accepts the result.
REQ-014 result_o  out  DATA_WIDTH  registered result.
REQ-015 adder_o  out  DATA_WIDTH+1  registered carry-extended A+B, or A-B for SUB and the compare ops.
REQ-016 comp_o  out  1  registered compare outcome.
REQ-017 busy_o  out  1  high while a multi-cycle op is iterating.

Function
REQ-018 Request handshake: a request is accepted on a rising edge where valid_i && ready_o.
REQ-019 Result handshake: a result is consumed on a rising edge where valid_o && ready_i.
REQ-020 Single-cycle ops: ADD, SUB, SLL, SRL, SRA, XOR, OR, AND, EQ, LT, LTU.
- The result is registered: valid_o rises on the edge after acceptance (latency 1).
REQ-021 Shift ops use operands_b_i[SHAMT_WIDTH-1:0]; SRA sign-fills.
REQ-022 Compare ops write result_o = {0..0, comp_o}; comp_o = raw compare XOR invert_i.
REQ-023 Multi-cycle ops: MUL (low half), MULHU (unsigned high half), DIVU, REMU, DIV, REM.
- Each uses one bit per cycle, DATA_WIDTH iterations.
- valid_o rises exactly DATA_WIDTH+1 edges after acceptance.
REQ-024 FSM states: IDLE, MUL, DIV, DONE.
- IDLE->MUL or IDLE->DIV on accepting a multi-cycle op.
- MUL/DIV->DONE when the iteration counter reaches DATA_WIDTH-1.
- DONE->IDLE loads the output register.
REQ-025 Iteration counter: $clog2(DATA_WIDTH) bits, cleared on entry, wraps only via the state exit.
REQ-026 busy_o = (state==MUL || state==DIV).
REQ-027 ready_o = (state==IDLE) && (!valid_o || ready_i).
- A new request is accepted in the same cycle the previous result is consumed, giving back-to-back single-cycle throughput of 1 per clock.
REQ-028 While valid_o && !ready_i, result_o, adder_o and comp_o SHALL hold stable; DONE SHALL not overwrite an unconsumed result.
- DONE waits for !valid_o || ready_i before loading.
REQ-029 Signed DIV/REM: operate on magnitudes, then negate the quotient if the signs differ and the remainder if A<0.
REQ-030 Divide by zero: quotient all-ones, remainder = A; full latency still applies.
REQ-031 Signed overflow (A = most-negative, B = -1): quotient = A, remainder = 0.
REQ-032 Unknown opcodes SHALL complete as single-cycle with result_o = 0 and comp_o = 0.
REQ-033 adder_o for multi-cycle ops SHALL be 0.

Reset
REQ-034 On rst_i high at a rising edge:
- state = IDLE; counter = 0.
- valid_o = 0; result_o = 0; adder_o = 0; comp_o = 0; busy_o = 0.
REQ-035 Reset mid-iteration SHALL abort the operation without producing a result; ready_o SHALL be 1 on the first cycle after rst_i falls.

Structure
REQ-036 Package core_exec_pkg SHALL hold:
- the alu_op_e enum (OP_WIDTH bits);
- the state enum;
- a helper function is_multicycle(alu_op_e).
REQ-037 Sub-module core_muldiv SHALL hold the shift-add multiplier and restoring divider datapaths, with start/done signals; the FSM stays in the parent.
REQ-038 All arithmetic SHALL be width-generic; no constant SHALL assume DATA_WIDTH=32.

Verification
REQ-039 ADD A=0xFFFFFFFF, B=1 -> valid_o after 1 edge, result_o=0, adder_o=0x1_00000000.
REQ-040 MUL A=7, B=6 -> valid_o exactly 33 edges after accept, result_o=42, busy_o high for 32 cycles.
REQ-041 DIV A=-7, B=2 -> result_o=0xFFFFFFFD (-3); REM same operands -> 0xFFFFFFFF (-1).
REQ-042 DIVU B=0, A=5 -> result_o=0xFFFFFFFF; REMU -> 5; DIV A=0x80000000, B=-1 -> 0x80000000.
REQ-043 Back-to-back ADD, ADD, LT with ready_i=1 -> three results on consecutive cycles.
- Then ready_i=0 for 4 cycles: result_o stable and ready_o=0.
REQ-044 Assert rst_i on cycle 10 of a DIVU -> no valid_o; next ADD 2+3 -> result_o=5 one edge after accept.
